// File: rtl/data_axi_bridge.sv
// -----------------------------------------------------------------------------
// data_axi_bridge
//   Data-side bridge between the MEM stage's SRAM-style RAM control interface
//   and a single-beat AXI master port. Each accepted request becomes exactly
//   one AXI read or write burst of length 1. The pipeline is held with
//   stall_req until the AXI transaction completes. A one-cycle DONE state then
//   releases the pipeline so the completing instruction is not reissued.
//
// Ports
//   clk, resetn         : clock, asynchronous active-low reset
//   ram_*               : request from MEM stage (en, byte strobes, addr,
//                         write data, size) and raw read word back
//   stall_req           : hold IF..MEM while a transaction is in flight
//   ar*/r*              : AXI read address / read data channels
//   aw*/w*/b*           : AXI write address / write data / write response
// -----------------------------------------------------------------------------
module data_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'b0001
) (
    input  logic        clk,
    input  logic        resetn,
    // MEM-stage RAM interface
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    input  logic [2:0]  ram_size,
    output logic [31:0] ram_read_data,
    output logic        stall_req,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    input  logic [3:0]  rid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    input  logic [3:0]  bid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic [31:0] phys_addr;
    logic        aw_hs;
    logic        w_hs;

    // Responses are assumed OK and IDs/last are implied by single-beat bursts.
    logic unused_resp;
    assign unused_resp = ^{rlast, rresp, rid, bresp, bid};

    // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) are unmapped windows onto the
    // low 512 MB; everything else is passed through untranslated.
    assign phys_addr = (ram_addr[31:30] == 2'b10) ? {3'b000, ram_addr[28:0]} : ram_addr;

    // AXI outputs depend only on registered state, so valids and payload
    // are glitch-free and stable until their handshake.
    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign awvalid = (state_q == WR_REQ) && !aw_done_q;

    assign wdata   = data_q;
    assign wstrb   = strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;

    assign bready  = (state_q == WR_RESP);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign ram_read_data = rdata_q;

    // Stall asserts combinationally in the request cycle so the pipeline
    // never advances past an unaccepted request; DONE is the only
    // non-idle state that lets it go.
    assign stall_req = ((state_q == IDLE) && ram_en) ||
                       (state_q inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP});

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        size_d    = size_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (ram_en) begin
                    addr_d    = phys_addr;
                    data_d    = ram_write_data;
                    size_d    = ram_size;
                    strb_d    = ram_write_en;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (ram_write_en == 4'b0000) ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once both have,
                // whether in the same cycle or spread over several.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) state_d = DONE;
            end
            DONE: begin
                // Request inputs still show the completing instruction here;
                // ignoring them prevents a duplicate access.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            size_q    <= 3'd0;
            strb_q    <= 4'd0;
            rdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            size_q    <= size_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_data_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_axi_bridge
//   Self-checking bench for data_axi_bridge. A cycle-stepped AXI slave with
//   per-channel ready/valid delays answers each request. Expectations come
//   from a directed table and from a reference model that derives the
//   physical address from the segment ranges, the stall length from the
//   slave delays and the read word from the last completed read.
// -----------------------------------------------------------------------------
module tb_data_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [2:0]  ram_size;
    logic [31:0] ram_read_data;
    logic        stall_req;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic [3:0]  bid;
    logic        bready;

    data_axi_bridge #(.AXI_ID(4'b0001)) dut (
        .clk(clk), .resetn(resetn),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_size(ram_size),
        .ram_read_data(ram_read_data), .stall_req(stall_req),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp),
        .rid(rid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdat;
        logic [2:0]  size;
        logic [31:0] rdat;
        int          ar_d, r_d, aw_d, w_d, b_d;
        bit          hold;
        logic [31:0] exp_addr;
        int          exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    logic [31:0] last_read;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference model: segment windows, slave-delay arithmetic, last read.
    function automatic vec_t model(input vec_t v, input logic [31:0] last);
        vec_t m = v;
        int wr_phase;
        if (v.addr >= 32'h8000_0000 && v.addr < 32'hA000_0000)
            m.exp_addr = v.addr - 32'h8000_0000;
        else if (v.addr >= 32'hA000_0000 && v.addr < 32'hC000_0000)
            m.exp_addr = v.addr - 32'hA000_0000;
        else
            m.exp_addr = v.addr;
        if (v.we == 4'b0000) begin
            m.exp_stall = 1 + (v.ar_d + 1) + (v.r_d + 1);
            m.exp_rdata = v.rdat;
        end else begin
            wr_phase    = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
            m.exp_stall = 1 + (wr_phase + 1) + (v.b_d + 1);
            m.exp_rdata = last;
        end
        return m;
    endfunction

    // Called at a falling edge with the bridge idle. Returns at the falling
    // edge of the cycle after DONE.
    task automatic run_txn(input vec_t v);
        int stall_cnt = 0;
        int ar_hi = 0, r_hi = 0, aw_hi = 0, w_hi = 0, b_hi = 0;
        int ar_bad = 0, aw_bad = 0, w_bad = 0;
        bit done = 0;
        bit is_rd = (v.we == 4'b0000);
        ram_en         = 1'b1;
        ram_write_en   = v.we;
        ram_addr       = v.addr;
        ram_write_data = v.wdat;
        ram_size       = v.size;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (stall_req) stall_cnt++;
            else done = 1;
            if (arvalid) begin
                ar_hi++;
                if (araddr !== v.exp_addr || arsize !== v.size || arlen !== 8'd0 ||
                    arburst !== 2'b01 || arid !== 4'b0001) ar_bad++;
            end
            if (rready) r_hi++;
            if (awvalid) begin
                aw_hi++;
                if (awaddr !== v.exp_addr || awsize !== v.size || awlen !== 8'd0 ||
                    awburst !== 2'b01 || awid !== 4'b0001) aw_bad++;
            end
            if (wvalid) begin
                w_hi++;
                if (wdata !== v.wdat || wstrb !== v.we || wlast !== 1'b1) w_bad++;
            end
            if (bready) b_hi++;
            arready = arvalid && (ar_hi > v.ar_d);
            rvalid  = rready  && (r_hi  > v.r_d);
            rdata   = v.rdat;
            awready = awvalid && (aw_hi > v.aw_d);
            wready  = wvalid  && (w_hi  > v.w_d);
            bvalid  = bready  && (b_hi  > v.b_d);
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: actual no DONE required DONE within 200 cycles");
        end
        check("stall_cycles", stall_cnt, v.exp_stall);
        check("ram_read_data", ram_read_data, v.exp_rdata);
        check("arvalid_cycles", ar_hi, is_rd ? v.ar_d + 1 : 0);
        check("rready_cycles",  r_hi,  is_rd ? v.r_d + 1  : 0);
        check("awvalid_cycles", aw_hi, is_rd ? 0 : v.aw_d + 1);
        check("wvalid_cycles",  w_hi,  is_rd ? 0 : v.w_d + 1);
        check("bready_cycles",  b_hi,  is_rd ? 0 : v.b_d + 1);
        check("field_stability", ar_bad + aw_bad + w_bad, 0);
        $display("txn %0d: %s addr=%h phys=%h stall=%0d read_data=%h hold=%0d",
                 txn_no, is_rd ? "RD" : "WR", v.addr, v.exp_addr, stall_cnt,
                 ram_read_data, v.hold);
        txn_no++;
        if (!v.hold) begin
            ram_en       = 1'b0;
            ram_write_en = 4'b0000;
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        bit saw_rd;
        resetn = 1'b0; ram_en = 1'b0; ram_write_en = 4'd0; ram_addr = 32'd0;
        ram_write_data = 32'd0; ram_size = 3'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b1; rresp = 2'b00;
        rid = 4'b0001; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        bresp = 2'b00; bid = 4'b0001;

        // addr, we, wdata, size, rdata, ar_d, r_d, aw_d, w_d, b_d, hold,
        // exp_addr, exp_stall, exp_rdata
        vecs[0] = '{32'h8000_1004, 4'b0000, 32'h0, 3'b010, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0,
                    32'h0000_1004, 3, 32'hDEAD_BEEF};
        vecs[1] = '{32'hBFC0_0003, 4'b1000, 32'h5A00_0000, 3'b000, 32'h0, 0, 0, 0, 2, 0, 0,
                    32'h1FC0_0003, 5, 32'hDEAD_BEEF};
        vecs[2] = '{32'hA000_0020, 4'b0000, 32'h0, 3'b010, 32'h0BAD_F00D, 4, 3, 0, 0, 0, 0,
                    32'h0000_0020, 10, 32'h0BAD_F00D};
        vecs[3] = '{32'h0040_0000, 4'b0000, 32'h0, 3'b001, 32'h1234_5678, 0, 0, 0, 0, 0, 0,
                    32'h0040_0000, 3, 32'h1234_5678};
        vecs[4] = '{32'h9000_0100, 4'b0000, 32'h0, 3'b010, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 1,
                    32'h1000_0100, 3, 32'hCAFE_F00D};
        vecs[5] = '{32'h0000_2000, 4'b1111, 32'h1122_3344, 3'b010, 32'hFFFF_FFFF, 0, 0, 1, 0, 2, 0,
                    32'h0000_2000, 6, 32'hCAFE_F00D};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid_wvalid", {awvalid, wvalid}, 0);
        check("rst_ready", {rready, bready}, 0);
        check("rst_read_data", ram_read_data, 0);
        check("rst_stall_idle", stall_req, 0);
        ram_en = 1'b1;
        #1 check("rst_stall_follows_en", stall_req, 1);
        ram_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);
        last_read = vecs[5].exp_rdata;

        // Randomized transactions against the reference model
        for (int i = 0; i < 24; i++) begin
            v.addr = {2'($urandom_range(0, 3)), 30'($urandom)};
            v.we   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            v.wdat = $urandom;
            v.size = 3'($urandom_range(0, 2));
            v.rdat = $urandom;
            v.ar_d = $urandom_range(0, 4);
            v.r_d  = $urandom_range(0, 4);
            v.aw_d = $urandom_range(0, 4);
            v.w_d  = $urandom_range(0, 4);
            v.b_d  = $urandom_range(0, 4);
            v.hold = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            v = model(v, last_read);
            last_read = v.exp_rdata;
            run_txn(v);
        end

        // Reset asserted while waiting in RD_DATA
        ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h8000_0040; ram_size = 3'b010;
        saw_rd = 0;
        for (int cyc = 0; cyc < 20 && !saw_rd; cyc++) begin
            #1;
            arready = arvalid;
            if (rready) saw_rd = 1;
            else @(negedge clk);
        end
        check("rst_reached_rd_data", saw_rd, 1);
        arready = 1'b0; rvalid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check("midrst_valids", {arvalid, awvalid, wvalid}, 0);
        check("midrst_readies", {rready, bready}, 0);
        check("midrst_read_data", ram_read_data, 0);
        check("midrst_stall_en", stall_req, 1);
        ram_en = 1'b0;
        #1 check("midrst_stall_noen", stall_req, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        $display("txn %0d: reset during RD_DATA, bridge returned to idle", txn_no);
        txn_no++;
        v = '{32'h8000_0008, 4'b0000, 32'h0, 3'b010, 32'h7654_3210, 0, 0, 0, 0, 0, 0,
              32'h0000_0008, 3, 32'h7654_3210};
        run_txn(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
